ni_packetizer: RTL

Local-port packet injector for one mesh node. It accepts a packet request (destination plus payload length) and a payload word stream from the attached processing element. It emits a header/body/tail flit sequence into the router's local input port, so the router's route-compute stage can decode it. The header carries the destination in the bit positions that route compute reads: X in [1:0], Y in [3:2].

---
 rtl/noc_pkg.sv | 47 ++++
 rtl/ni_flit_reg.sv | 30 +++
 rtl/ni_packetizer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, router port codes, mesh geometry,
// header field layout and the packetizer FSM state type.
package noc_pkg;

  localparam logic [1:0] FLIT_HDR  = 2'b10;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b01;

  localparam logic [2:0] PORT_L = 3'd1;
  localparam logic [2:0] PORT_E = 3'd2;
  localparam logic [2:0] PORT_N = 3'd3;
  localparam logic [2:0] PORT_W = 3'd4;
  localparam logic [2:0] PORT_S = 3'd5;

  localparam int MESH_X  = 4;
  localparam int MESH_Y  = 4;
  localparam int COORD_W = 2;

  // Bit offsets of the coordinate fields inside the header flit data
  localparam int HDR_DX_LSB = 0;
  localparam int HDR_DY_LSB = 2;
  localparam int HDR_SX_LSB = 4;
  localparam int HDR_SY_LSB = 6;
  localparam int HDR_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_DROP = 2'b10
  } ni_state_e;

  function automatic logic [HDR_W-1:0] make_header(
    input logic [COORD_W-1:0] dx,
    input logic [COORD_W-1:0] dy,
    input logic [COORD_W-1:0] sx,
    input logic [COORD_W-1:0] sy
  );
    logic [HDR_W-1:0] h;
    h = '0;
    h[HDR_DX_LSB +: COORD_W] = dx;
    h[HDR_DY_LSB +: COORD_W] = dy;
    h[HDR_SX_LSB +: COORD_W] = sx;
    h[HDR_SY_LSB +: COORD_W] = sy;
    return h;
  endfunction

endpackage

// File: rtl/ni_flit_reg.sv
// Holding output register toward the router local port: a load writes a new
// flit, a transfer (valid && ready) empties it, otherwise contents stay put.
module ni_flit_reg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         flit_ready,
  output logic         flit_valid,
  output logic [W-1:0] flit_data
);

  // Load has priority so a transfer and the next load can share one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flit_valid <= 1'b0;
      flit_data  <= '0;
    end else if (load) begin
      flit_valid <= 1'b1;
      flit_data  <= load_data;
    end else if (flit_valid && flit_ready) begin
      flit_valid <= 1'b0;
    end else begin
      flit_valid <= flit_valid;
    end
  end

endmodule

// File: rtl/ni_packetizer.sv
// Local-port packet injector: turns a request plus payload stream into a
// HDR/BODY/TAIL flit sequence. Optional macro: NI_SELF_DEST_DROP_EN.
module ni_packetizer
  import noc_pkg::*;
#(
  parameter int X_S_ADRESS = 0,
  parameter int Y_S_ADRESS = 2,
  parameter int DATA_W     = 8,
  parameter int LEN_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic [1:0]        dest_x,
  input  logic [1:0]        dest_y,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic              pl_valid,
  input  logic [DATA_W-1:0] pl_data,
  output logic              pl_ready,
  output logic              flit_valid,
  output logic [DATA_W+1:0] flit_data,
  input  logic              flit_ready,
  output logic [7:0]        pkt_cnt
`ifdef NI_SELF_DEST_DROP_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam logic [COORD_W-1:0] SELF_X   = COORD_W'(X_S_ADRESS);
  localparam logic [COORD_W-1:0] SELF_Y   = COORD_W'(Y_S_ADRESS);
  localparam logic [LEN_W-1:0]   LEN_ZERO = LEN_W'(0);
  localparam logic [LEN_W-1:0]   LEN_ONE  = LEN_W'(1);

  ni_state_e         state_r;
  ni_state_e         state_nxt_s;
  logic [LEN_W-1:0]  rem_r;
  logic [LEN_W-1:0]  rem_nxt_s;
  logic [LEN_W-1:0]  len_eff_s;
  logic [DATA_W-1:0] hdr_s;
  logic              load_s;
  logic [DATA_W+1:0] load_data_s;
  logic              flit_free_s;
  logic              tail_done_s;
`ifdef NI_SELF_DEST_DROP_EN
  logic              self_dest_s;
  logic              drop_done_s;

  assign self_dest_s = (dest_x == SELF_X) && (dest_y == SELF_Y);
`endif

  // A zero-length request still carries one payload word in its TAIL
  assign len_eff_s   = (pkt_len == LEN_ZERO) ? LEN_ONE : pkt_len;
  assign flit_free_s = !flit_valid || flit_ready;

  // Header word: coordinate fields in the low byte, upper bits zero
  always_comb begin
    hdr_s      = '0;
    hdr_s[7:0] = make_header(dest_x, dest_y, SELF_X, SELF_Y);
  end

  // Next-state, payload handshake and output-register load control
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    load_s      = 1'b0;
    load_data_s = '0;
    pl_ready    = 1'b0;
    tail_done_s = 1'b0;
`ifdef NI_SELF_DEST_DROP_EN
    drop_done_s = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (pkt_valid && pkt_ready) begin
          rem_nxt_s = len_eff_s;
`ifdef NI_SELF_DEST_DROP_EN
          if (self_dest_s) begin
            state_nxt_s = ST_DROP;
          end else begin
            state_nxt_s = ST_SEND;
            load_s      = 1'b1;
            load_data_s = {FLIT_HDR, hdr_s};
          end
`else
          state_nxt_s = ST_SEND;
          load_s      = 1'b1;
          load_data_s = {FLIT_HDR, hdr_s};
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (rem_r != LEN_ZERO) begin
          pl_ready = flit_free_s;
          if (pl_valid && flit_free_s) begin
            load_s      = 1'b1;
            load_data_s = {(rem_r == LEN_ONE) ? FLIT_TAIL : FLIT_BODY, pl_data};
            rem_nxt_s   = rem_r - LEN_ONE;
          end else begin
            rem_nxt_s = rem_r;
          end
        end else if (flit_valid && flit_ready) begin
          // Only the TAIL can be pending once every word has been loaded
          state_nxt_s = ST_IDLE;
          tail_done_s = 1'b1;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
`ifdef NI_SELF_DEST_DROP_EN
      ST_DROP: begin
        pl_ready = 1'b1;
        if (pl_valid) begin
          rem_nxt_s = rem_r - LEN_ONE;
          if (rem_r == LEN_ONE) begin
            state_nxt_s = ST_IDLE;
            drop_done_s = 1'b1;
          end else begin
            state_nxt_s = ST_DROP;
          end
        end else begin
          rem_nxt_s = rem_r;
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, remaining-word counter, request-ready and packet counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      rem_r     <= LEN_ZERO;
      pkt_ready <= 1'b0;
      pkt_cnt   <= 8'd0;
    end else begin
      state_r   <= state_nxt_s;
      rem_r     <= rem_nxt_s;
      pkt_ready <= (state_nxt_s == ST_IDLE);
      if (tail_done_s) begin
        pkt_cnt <= pkt_cnt + 8'd1;
      end else begin
        pkt_cnt <= pkt_cnt;
      end
    end
  end

`ifdef NI_SELF_DEST_DROP_EN
  // Count self-addressed packets that were swallowed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (drop_done_s) begin
      drop_cnt <= drop_cnt + 8'd1;
    end else begin
      drop_cnt <= drop_cnt;
    end
  end
`endif

  ni_flit_reg #(
    .W (DATA_W + 2)
  ) u_flit_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load_s),
    .load_data  (load_data_s),
    .flit_ready (flit_ready),
    .flit_valid (flit_valid),
    .flit_data  (flit_data)
  );

endmodule
